hazard_bubble_seq: RTL and testbench
====================================

Name: hazard_bubble_seq

Overview:
- Parametrised successor to the fetch-stage no-op inserter.
- Sits between instruction fetch and decode. Registers each fetched instruction through to decode.
- After control-flow and load instructions, it inserts a per-class, configurable number of NOP bubbles. It back-pressures fetch until the bubbles have drained.
- Adds downstream stall, flush, a bypass mode and a saturating bubble statistic.

Parameters:
WIDTH, 32, instruction word width (opcode = [WIDTH-1:WIDTH-6], funct = [5:0])
NOP_WORD, 32'h20000000, word emitted as a bubble (addi $0,$0,0)
JUMP_BUBBLES, 2, bubbles after JR/J/JAL (0..7)
BRANCH_BUBBLES, 2, bubbles after BEQ/BNE (0..7)
LOAD_BUBBLES, 1, bubbles after LW (0..7)
STAT_W, 16, width of bubble statistic counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_instr  in  WIDTH  fetched instruction
in_valid  in  1  in_instr valid
in_ready  out  1  sequencer accepts in_instr this cycle (fetch must hold PC when low)
stall  in  1  decode stall; freeze all state
flush  in  1  discard current output and pending bubbles
bubble_en  in  1  1 = insert bubbles; 0 = pure registered pass-through
out_instr  out  WIDTH  instruction to decode
out_valid  out  1  out_instr valid
out_is_bubble  out  1  out_instr is an inserted NOP
bubbles_left  out  3  bubbles still to emit
bubble_total  out  STAT_W  saturating count of emitted bubbles

Behaviour:
- Reset (when reset=1 at an edge):
  - state=IDLE, bubbles_left=0, bubble_total=0.
  - out_instr=NOP_WORD, out_valid=0, out_is_bubble=0.
  - Reset overrides flush and stall.
- Classification (combinational on in_instr):
  - JUMP: opcode 000000 with funct 001000 (JR); opcode 000010 (J); opcode 000011 (JAL).
  - BRANCH: opcode 000100 or 000101.
  - LOAD: opcode 100011.
  - All other opcodes (e.g. ADDI 001000) are NONE, with 0 bubbles.
- States: IDLE, BUBBLE.
- in_ready = (state==IDLE) & ~stall & ~reset. Accept means in_valid & in_ready at an edge.
- IDLE, no stall:
  - On accept: out_instr<=in_instr, out_valid<=1, out_is_bubble<=0. Latency is 1 cycle.
  - If bubble_en and the class count N>0: bubbles_left<=N, state<=BUBBLE.
  - Otherwise the state stays IDLE.
  - No accept: out_instr<=NOP_WORD, out_valid<=0, out_is_bubble<=0.
- BUBBLE, no stall, each edge:
  - out_instr<=NOP_WORD, out_valid<=1, out_is_bubble<=1.
  - bubbles_left<=bubbles_left-1.
  - bubble_total<=bubble_total+1, saturating at all-ones with no wrap.
  - If bubbles_left==1: state<=IDLE.
- Result: a hazard instruction is followed by exactly N consecutive NOPs. in_ready is low for exactly N cycles after the accept. The next instruction can be accepted on the edge that emits the last NOP's successor, so no gap cycle appears.
- stall=1: all registers hold, including outputs, bubbles_left and bubble_total. in_ready=0.
- flush=1 (no reset), overrides stall:
  - state<=IDLE, bubbles_left<=0, out_valid<=0, out_is_bubble<=0, out_instr<=NOP_WORD.
  - No accept occurs that cycle; in_ready=0 while flush=1.
  - bubble_total is not cleared.
- bubble_en sampling:
  - Sampled only at accept. Dropping it mid-BUBBLE does not cancel the bubbles already scheduled.
- Unused parameter values: a class parameter of 0 yields no bubbles and no BUBBLE entry for that class.

Test Plan:
- JR (0x03E00008) with in_valid=1, defaults, bubble_en=1 → t+1: out=0x03E00008, valid=1, bubble=0. t+2 and t+3: out=0x20000000, bubble=1. in_ready low at t+1 and t+2. Next ADDI (0x23FFFFC8) appears at t+4. bubble_total=2.
- LW (0x8FFFFFC8), then ADDI → LW, one NOP, ADDI on consecutive cycles. bubbles_left sequence is 1,0.
- ADDI stream (0x23FFFFC8 ×3) → passes back-to-back with 1-cycle latency. in_ready stays 1, bubble_total stays 0.
- BEQ accepted, stall=1 held for 3 cycles during the first bubble → output, bubbles_left and in_ready frozen. Exactly 2 NOPs total after the stall is released.
- JR accepted, flush=1 on the first bubble cycle → next cycle valid=0, bubbles_left=0, in_ready=1. bubble_total=1 if one bubble was emitted before the flush, else 0.
- bubble_en=0 with JR,LW,BEQ back-to-back → all pass through with no NOPs. Reset asserted mid-BUBBLE → next cycle out_valid=0, out_instr=0x20000000, bubble_total=0.

Source files
------------

// File: rtl/hazard_bubble_seq.sv
// Fetch-to-decode register that inserts per-class NOP bubbles after jumps, branches and loads,
// holding fetch off while bubbles drain; also supports stall, flush, bypass and a bubble count.
module hazard_bubble_seq #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(32'h20000000),
    parameter int JUMP_BUBBLES = 2,
    parameter int BRANCH_BUBBLES = 2,
    parameter int LOAD_BUBBLES = 1,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              bubble_en,
    output logic [WIDTH-1:0]  out_instr,
    output logic              out_valid,
    output logic              out_is_bubble,
    output logic [2:0]        bubbles_left,
    output logic [STAT_W-1:0] bubble_total
);

    typedef enum logic {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam logic [2:0] JUMP_N   = 3'(JUMP_BUBBLES);
    localparam logic [2:0] BRANCH_N = 3'(BRANCH_BUBBLES);
    localparam logic [2:0] LOAD_N   = 3'(LOAD_BUBBLES);

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [2:0] classBubbles;
    logic       accept;

    // Bubble count owed by the instruction currently offered by fetch.
    always_comb begin
        opcode       = in_instr[WIDTH-1 -: 6];
        funct        = in_instr[5:0];
        classBubbles = 3'd0;
        case (opcode)
            6'b000000: if (funct == 6'b001000) classBubbles = JUMP_N;
            6'b000010,
            6'b000011: classBubbles = JUMP_N;
            6'b000100,
            6'b000101: classBubbles = BRANCH_N;
            6'b100011: classBubbles = LOAD_N;
            default:   classBubbles = 3'd0;
        endcase
    end

    assign in_ready = (state == IDLE) & ~stall & ~flush & ~reset;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bubbles_left  <= 3'd0;
            bubble_total  <= '0;
            out_instr     <= NOP_WORD;
            out_valid     <= 1'b0;
            out_is_bubble <= 1'b0;
        end else if (flush) begin
            // Flush drops pending bubbles but keeps the statistic.
            state         <= IDLE;
            bubbles_left  <= 3'd0;
            out_instr     <= NOP_WORD;
            out_valid     <= 1'b0;
            out_is_bubble <= 1'b0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_instr     <= in_instr;
                        out_valid     <= 1'b1;
                        out_is_bubble <= 1'b0;
                        if (bubble_en && (classBubbles != 3'd0)) begin
                            bubbles_left <= classBubbles;
                            state        <= BUBBLE;
                        end
                    end else begin
                        out_instr     <= NOP_WORD;
                        out_valid     <= 1'b0;
                        out_is_bubble <= 1'b0;
                    end
                end
                BUBBLE: begin
                    out_instr     <= NOP_WORD;
                    out_valid     <= 1'b1;
                    out_is_bubble <= 1'b1;
                    bubbles_left  <= bubbles_left - 3'd1;
                    if (bubble_total != STAT_MAX) begin
                        bubble_total <= bubble_total + STAT_ONE;
                    end
                    if (bubbles_left == 3'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bubbles_left <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_bubble_seq.sv
// Directed bench for hazard_bubble_seq: an expected-output queue model checked every cycle,
// plus hand-computed literal checks along the directed sequence.
module tb_hazard_bubble_seq;

    localparam int WIDTH  = 32;
    localparam int STAT_W = 4;

    localparam logic [31:0] NOP  = 32'h20000000;
    localparam logic [31:0] JR   = 32'h03E00008;
    localparam logic [31:0] ADDI = 32'h23FFFFC8;
    localparam logic [31:0] LW   = 32'h8FFFFFC8;
    localparam logic [31:0] BEQ  = 32'h1000FFFF;
    localparam logic [31:0] BNE  = 32'h14000004;
    localparam logic [31:0] JMP  = 32'h08000010;
    localparam logic [31:0] JAL  = 32'h0C000010;
    localparam logic [31:0] ADD  = 32'h00221820;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  in_instr;
    logic              in_valid;
    logic              in_ready;
    logic              stall;
    logic              flush;
    logic              bubble_en;
    logic [WIDTH-1:0]  out_instr;
    logic              out_valid;
    logic              out_is_bubble;
    logic [2:0]        bubbles_left;
    logic [STAT_W-1:0] bubble_total;

    hazard_bubble_seq #(
        .WIDTH (WIDTH),
        .STAT_W(STAT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .bubble_en    (bubble_en),
        .out_instr    (out_instr),
        .out_valid    (out_valid),
        .out_is_bubble(out_is_bubble),
        .bubbles_left (bubbles_left),
        .bubble_total (bubble_total)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int nVec  = 0;
    int nMiss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // exp_q holds the words still owed to decode: {isBubble, word}.
    logic [WIDTH:0] exp_q[$];
    logic [31:0]    expOut   = NOP;
    logic           expValid = 1'b0;
    logic           expBub   = 1'b0;
    int             expTotal = 0;
    bit             started  = 1'b0;

    function automatic int classCount(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h00 && w[5:0] == 6'h08) return 2;
        if (op == 6'h02 || op == 6'h03)     return 2;
        if (op == 6'h04 || op == 6'h05)     return 2;
        if (op == 6'h23)                    return 1;
        return 0;
    endfunction

    initial begin
        logic [WIDTH:0] e;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                expOut = NOP; expValid = 1'b0; expBub = 1'b0; expTotal = 0;
                started = 1'b1;
            end else if (flush) begin
                exp_q.delete();
                expOut = NOP; expValid = 1'b0; expBub = 1'b0;
            end else if (!stall) begin
                if (exp_q.size() == 0 && in_valid) begin
                    exp_q.push_back({1'b0, in_instr});
                    if (bubble_en)
                        for (int i = 0; i < classCount(in_instr); i++) exp_q.push_back({1'b1, NOP});
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    expOut = e[WIDTH-1:0]; expBub = e[WIDTH]; expValid = 1'b1;
                    if (e[WIDTH]) expTotal = (expTotal + 1 > (1 << STAT_W) - 1) ? (1 << STAT_W) - 1 : expTotal + 1;
                end else begin
                    expOut = NOP; expValid = 1'b0; expBub = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("out_instr",     out_instr,     expOut);
                check("out_valid",     out_valid,     expValid);
                check("out_is_bubble", out_is_bubble, expBub);
                check("bubbles_left",  bubbles_left,  exp_q.size());
                check("bubble_total",  bubble_total,  expTotal);
                check("in_ready",      in_ready,
                      (exp_q.size() == 0) && !stall && !flush && !reset);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] w);
        in_instr = w;
        in_valid = 1'b1;
    endtask

    logic [31:0] tblWord[6] = '{BNE, JMP, JAL, ADD, LW, ADDI};
    int          tblN[6]    = '{2, 2, 2, 0, 1, 0};

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; stall = 1'b1; flush = 1'b1; bubble_en = 1'b1;
        present(JR);
        tick(); tick();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_instr", out_instr, NOP);
        check("rst out_is_bubble", out_is_bubble, 1'b0);
        check("rst bubbles_left", bubbles_left, 3'd0);
        check("rst bubble_total", bubble_total, 0);
        #1 check("rst in_ready", in_ready, 1'b1);

        // JR followed by ADDI held by fetch
        present(JR); tick();
        check("jr out", out_instr, JR);
        check("jr bubble flag", out_is_bubble, 1'b0);
        check("jr left", bubbles_left, 3'd2);
        present(ADDI); #1;
        check("jr ready t+1", in_ready, 1'b0);
        tick();
        check("jr nop1", out_instr, NOP);
        check("jr nop1 flag", out_is_bubble, 1'b1);
        check("jr ready t+2", in_ready, 1'b0);
        tick();
        check("jr nop2 flag", out_is_bubble, 1'b1);
        check("jr nop2 left", bubbles_left, 3'd0);
        check("jr total", bubble_total, 2);
        tick();
        check("jr next addi", out_instr, ADDI);
        in_valid = 1'b0; tick();
        check("jr idle valid", out_valid, 1'b0);

        // LW then ADDI
        present(LW); tick();
        check("lw left", bubbles_left, 3'd1);
        present(ADDI); tick();
        check("lw nop", out_is_bubble, 1'b1);
        check("lw left0", bubbles_left, 3'd0);
        tick();
        check("lw addi", out_instr, ADDI);
        in_valid = 1'b0; tick();

        // back-to-back ADDI
        present(ADDI);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("addi stream", out_instr, ADDI);
            check("addi ready", in_ready, 1'b1);
        end
        check("addi total", bubble_total, 3);
        in_valid = 1'b0; tick();

        // BEQ with a 3-cycle stall on the first bubble
        present(BEQ); tick();
        in_valid = 1'b0; tick();
        check("beq left1", bubbles_left, 3'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall out", out_instr, NOP);
            check("stall left", bubbles_left, 3'd1);
            check("stall ready", in_ready, 1'b0);
        end
        stall = 1'b0; tick();
        check("beq nop2", out_is_bubble, 1'b1);
        tick();
        check("beq done", out_valid, 1'b0);
        check("beq total", bubble_total, 5);

        // JR flushed on its first bubble cycle
        present(JR); tick();
        in_valid = 1'b0; flush = 1'b1; tick();
        check("flush valid", out_valid, 1'b0);
        check("flush left", bubbles_left, 3'd0);
        check("flush total", bubble_total, 5);
        flush = 1'b0; #1;
        check("flush ready", in_ready, 1'b1);

        // flush wins over stall
        present(BEQ); tick();
        in_valid = 1'b0; stall = 1'b1; flush = 1'b1; tick();
        check("flush>stall left", bubbles_left, 3'd0);
        stall = 1'b0; flush = 1'b0; tick();

        // remaining classes
        for (int k = 0; k < 6; k++) begin
            present(tblWord[k]); tick();
            check("class left", bubbles_left, tblN[k]);
            in_valid = 1'b0;
            repeat (tblN[k]) tick();
        end
        check("class total", bubble_total, 12);

        // bypass mode
        bubble_en = 1'b0;
        present(JR);  tick(); check("byp jr", out_instr, JR);
        present(LW);  tick(); check("byp lw", out_instr, LW);
        present(BEQ); tick(); check("byp beq", out_instr, BEQ);
        check("byp left", bubbles_left, 3'd0);
        in_valid = 1'b0; tick();

        // bubble_en dropped mid-bubble keeps scheduled bubbles
        bubble_en = 1'b1;
        present(JR); tick();
        bubble_en = 1'b0; in_valid = 1'b0; tick();
        check("drop nop1", out_is_bubble, 1'b1);
        tick();
        check("drop nop2", out_is_bubble, 1'b1);
        check("drop total", bubble_total, 14);
        bubble_en = 1'b1;

        // statistic saturation
        for (int k = 0; k < 2; k++) begin
            present(JAL); tick();
            in_valid = 1'b0; tick(); tick();
        end
        check("sat total", bubble_total, 15);

        // reset mid-bubble
        present(JR); tick();
        in_valid = 1'b0; tick();
        reset = 1'b1; tick();
        check("midrst valid", out_valid, 1'b0);
        check("midrst out", out_instr, NOP);
        check("midrst total", bubble_total, 0);
        check("midrst left", bubbles_left, 3'd0);
        reset = 1'b0; tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
